// File: rtl/sa_out_accum_buf.sv
// sa_out_accum_buf: deskews the column-skewed SA result stream, accumulates K partial tiles in Q2.13
// and hands the finished tile to a double-buffered valid/ready output. Define SA_ACC_SAT_EN for saturating adds.
module sa_out_accum_buf #(
  parameter int unsigned D_W  = 16,
  parameter int unsigned SA_R = 16,
  parameter int unsigned SA_C = 16,
  parameter int unsigned K_W  = 4
) (
  input  logic                                  I_CLK,
  input  logic                                  I_RST,
  input  logic                                  I_START,
  input  logic [K_W-1:0]                        I_K_TILES,
  input  logic                                  I_D_VLD,
  input  logic [0:SA_C-1][D_W-1:0]              I_D,
  output logic                                  O_IN_RDY,
  output logic                                  O_BUSY,
  output logic                                  O_OUT_VLD,
  input  logic                                  I_OUT_RDY,
  output logic [0:SA_R-1][0:SA_C-1][D_W-1:0]    O_OUT,
  output logic                                  O_SAT
);

  localparam int unsigned BEATS = SA_R + SA_C - 1;
  localparam int unsigned BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned RW    = (SA_R > 1) ? $clog2(SA_R) : 1;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                             state;
  logic [K_W-1:0]                     k_total;
  logic [K_W-1:0]                     tile_cnt;
  logic [BC_W-1:0]                    beat_cnt;
  logic                               sat_acc;
  logic [0:SA_R-1][0:SA_C-1][D_W-1:0] acc;

  logic                               beat_acc_c;
  logic                               drain_go_c;
  logic [0:SA_C-1]                    lane_live;
  logic [0:SA_C-1][RW-1:0]            lane_row;
  logic [0:SA_C-1][D_W-1:0]           lane_val;
  logic [0:SA_C-1]                    lane_sat;

  assign beat_acc_c = I_D_VLD && O_IN_RDY;
  assign drain_go_c = (state == DRAIN) && (!O_OUT_VLD || I_OUT_RDY);

  // Per-lane deskew target and the reduced value to write into the accumulator bank
  always_comb begin : p_lane
`ifdef SA_ACC_SAT_EN
    logic [D_W:0] sum;
    sum = '0;
`endif
    lane_live = '0;
    lane_row  = '0;
    lane_val  = '0;
    lane_sat  = '0;
    for (int unsigned j = 0; j < SA_C; j++) begin
      if ((32'(beat_cnt) >= j) && (32'(beat_cnt) < j + SA_R)) begin
        lane_live[j] = 1'b1;
        lane_row[j]  = RW'(32'(beat_cnt) - j);
      end
      if (tile_cnt == '0) begin
        lane_val[j] = I_D[j];
      end else begin
`ifdef SA_ACC_SAT_EN
        sum = {acc[lane_row[j]][j][D_W-1], acc[lane_row[j]][j]} + {I_D[j][D_W-1], I_D[j]};
        if (sum[D_W] != sum[D_W-1]) begin
          lane_val[j] = sum[D_W] ? {1'b1, {(D_W-1){1'b0}}} : {1'b0, {(D_W-1){1'b1}}};
          lane_sat[j] = lane_live[j];
        end else begin
          lane_val[j] = sum[D_W-1:0];
        end
`else
        lane_val[j] = acc[lane_row[j]][j] + I_D[j];
`endif
      end
    end
  end

  // Accumulator bank: only live lanes of an accepted beat are written
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      acc <= '0;
    end else if (beat_acc_c) begin
      for (int unsigned j = 0; j < SA_C; j++) begin
        if (lane_live[j]) begin
          acc[lane_row[j]][j] <= lane_val[j];
        end
      end
    end
  end

  // Job control and the registered output bank
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state     <= IDLE;
      k_total   <= '0;
      tile_cnt  <= '0;
      beat_cnt  <= '0;
      sat_acc   <= 1'b0;
      O_IN_RDY  <= 1'b0;
      O_BUSY    <= 1'b0;
      O_OUT_VLD <= 1'b0;
      O_OUT     <= '0;
      O_SAT     <= 1'b0;
    end else begin
      if (O_OUT_VLD && I_OUT_RDY) begin
        O_OUT_VLD <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (I_START) begin
            state    <= ACCUM;
            k_total  <= (I_K_TILES == '0) ? K_W'(1) : I_K_TILES;
            tile_cnt <= '0;
            beat_cnt <= '0;
            sat_acc  <= 1'b0;
            O_IN_RDY <= 1'b1;
            O_BUSY   <= 1'b1;
          end
        end
        ACCUM: begin
          if (beat_acc_c) begin
            sat_acc <= sat_acc | (|lane_sat);
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              tile_cnt <= tile_cnt + K_W'(1);
              if (tile_cnt == k_total - K_W'(1)) begin
                state    <= DRAIN;
                O_IN_RDY <= 1'b0;
              end
            end else begin
              beat_cnt <= beat_cnt + BC_W'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_go_c) begin
            O_OUT     <= acc;
            O_SAT     <= sat_acc;
            O_OUT_VLD <= 1'b1;
            O_BUSY    <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          O_IN_RDY <= 1'b0;
          O_BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sa_out_accum_buf.sv
// Scoreboard bench for sa_out_accum_buf: a tile-level arithmetic model predicts each job's result,
// and a monitor compares every output handshake against the queued predictions.
`timescale 1ns/1ps
module tb_sa_out_accum_buf;
  localparam int unsigned D_W   = 16;
  localparam int unsigned SA_R  = 16;
  localparam int unsigned SA_C  = 16;
  localparam int unsigned K_W   = 4;
  localparam int unsigned BEATS = SA_R + SA_C - 1;
  localparam int          KMAX  = 16;
  localparam int          SMAX  = (1 << (D_W - 1)) - 1;
  localparam int          SMIN  = -(1 << (D_W - 1));

  typedef logic [0:SA_R-1][0:SA_C-1][D_W-1:0] tile_t;

  logic                     I_CLK = 1'b0;
  logic                     I_RST = 1'b1;
  logic                     I_START = 1'b0;
  logic [K_W-1:0]           I_K_TILES = '0;
  logic                     I_D_VLD = 1'b0;
  logic [0:SA_C-1][D_W-1:0] I_D = '0;
  logic                     I_OUT_RDY = 1'b0;
  logic                     O_IN_RDY, O_BUSY, O_OUT_VLD, O_SAT;
  tile_t                    O_OUT;

  int    checks = 0;
  int    errors = 0;
  tile_t exp_q[$];
  bit    exp_sat_q[$];
  tile_t part [KMAX];
  bit    rdy_rand = 1'b0;
  int    gap_pct = 0;

  sa_out_accum_buf #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .K_W(K_W)) dut (
    .I_CLK(I_CLK), .I_RST(I_RST), .I_START(I_START), .I_K_TILES(I_K_TILES),
    .I_D_VLD(I_D_VLD), .I_D(I_D), .O_IN_RDY(O_IN_RDY), .O_BUSY(O_BUSY),
    .O_OUT_VLD(O_OUT_VLD), .I_OUT_RDY(I_OUT_RDY), .O_OUT(O_OUT), .O_SAT(O_SAT)
  );

  always #5 I_CLK = ~I_CLK;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial forever begin
    @(posedge I_CLK);
    #1;
    if (rdy_rand) I_OUT_RDY = ($urandom_range(0, 99) < 60);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_tile(input string name, input tile_t act, input tile_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int r = 0; r < SA_R; r++)
        for (int c = 0; c < SA_C; c++)
          if (act[r][c] !== exp[r][c]) begin
            $display("FAIL %s at r=%0d c=%0d actual=%h expected=%h", name, r, c, act[r][c], exp[r][c]);
            return;
          end
    end
  endtask

  // Reference: element-wise sum of the partial tiles, reduced to D_W bits after every add
  task automatic model(input int kt, output tile_t t, output bit sat);
    sat = 1'b0;
    t = '0;
    for (int r = 0; r < SA_R; r++)
      for (int c = 0; c < SA_C; c++) begin
        int s;
        s = 0;
        for (int k = 0; k < kt; k++) begin
          int v;
          v = int'($signed(part[k][r][c]));
          s = (k == 0) ? v : s + v;
`ifdef SA_ACC_SAT_EN
          if (s > SMAX) begin s = SMAX; sat = 1'b1; end
          else if (s < SMIN) begin s = SMIN; sat = 1'b1; end
`else
          if (s > SMAX) s = s - (1 << D_W);
          else if (s < SMIN) s = s + (1 << D_W);
`endif
        end
        t[r][c] = D_W'(s);
      end
  endtask

  task automatic fill_const(input int kt, input logic [D_W-1:0] v);
    for (int k = 0; k < kt; k++) part[k] = {(SA_R * SA_C){v}};
  endtask

  task automatic fill_rand(input int kt, input bit full_range);
    for (int k = 0; k < kt; k++)
      for (int r = 0; r < SA_R; r++)
        for (int c = 0; c < SA_C; c++)
          part[k][r][c] = full_range ? D_W'($urandom) : D_W'(int'($urandom_range(0, 4095)) - 2048);
  endtask

  // Drives one job from part[]; returns #1 after the edge that accepted the final (or abort) beat
  task automatic run_job(input int k_in, input bit dead_fill, input int abort_beat);
    int    kt, total, idx, cyc, n;
    tile_t et;
    bit    es;
    bit    vld, rdy_now;
    kt = (k_in == 0) ? 1 : k_in;
    model(kt, et, es);
    exp_q.push_back(et);
    exp_sat_q.push_back(es);
    n = 0;
    while (O_BUSY && n < 2000) begin @(posedge I_CLK); #1; n++; end
    if (O_BUSY) begin
      checks++; errors++;
      $display("FAIL job_wait_idle busy=%b required=0", O_BUSY);
      return;
    end
    I_START = 1'b1;
    I_K_TILES = K_W'(k_in);
    @(posedge I_CLK); #1;
    I_START = 1'b0;
    total = kt * BEATS;
    idx = 0;
    cyc = 0;
    while (idx < total && cyc < total * 20 + 100) begin
      int b, k;
      b = idx % BEATS;
      k = idx / BEATS;
      vld = ($urandom_range(0, 99) >= gap_pct);
      for (int j = 0; j < SA_C; j++)
        if (j <= b && b < j + SA_R) I_D[j] = part[k][b-j][j];
        else I_D[j] = dead_fill ? 16'hDEAD : D_W'($urandom);
      I_D_VLD = vld;
      rdy_now = O_IN_RDY;
      @(posedge I_CLK);
      cyc++;
      if (vld && rdy_now) idx++;
      #1;
      if (idx == abort_beat) begin
        I_D_VLD = 1'b0;
        void'(exp_q.pop_back());
        void'(exp_sat_q.pop_back());
        return;
      end
    end
    I_D_VLD = 1'b0;
    if (idx < total) begin
      checks++; errors++;
      $display("FAIL job_beats accepted=%0d required=%0d", idx, total);
    end
  endtask

  task automatic drain_queue();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(posedge I_CLK); #1; n++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_queue pending=%0d required=0", exp_q.size());
    end
  endtask

  // Monitor: score each handshake and check output stability under backpressure
  tile_t mon_prev;
  bit    mon_prev_sat;
  bit    mon_stall = 1'b0;
  always @(negedge I_CLK) begin
    if (I_RST) begin
      mon_stall = 1'b0;
    end else begin
      if (mon_stall) begin
        chk("hold_vld", 32'(O_OUT_VLD), 32'd1);
        chk("hold_sat", 32'(O_SAT), 32'(mon_prev_sat));
        chk_tile("hold_out", O_OUT, mon_prev);
      end
      if (O_OUT_VLD && I_OUT_RDY) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tile vld=%b queued=0", O_OUT_VLD);
        end else begin
          tile_t e;
          bit    es;
          e = exp_q.pop_front();
          es = exp_sat_q.pop_front();
          chk_tile("tile_data", O_OUT, e);
          chk("tile_sat", 32'(O_SAT), 32'(es));
        end
      end
      mon_stall = O_OUT_VLD && !I_OUT_RDY;
      mon_prev = O_OUT;
      mon_prev_sat = O_SAT;
    end
  end

  initial begin
    tile_t exp_a, exp_b;
    repeat (3) @(posedge I_CLK);
    #1;
    chk("rst_vld", 32'(O_OUT_VLD), 32'd0);
    chk("rst_busy", 32'(O_BUSY), 32'd0);
    chk("rst_in_rdy", 32'(O_IN_RDY), 32'd0);
    chk("rst_sat", 32'(O_SAT), 32'd0);
    chk_tile("rst_out", O_OUT, '0);
    I_RST = 1'b0;
    I_OUT_RDY = 1'b1;
    @(posedge I_CLK); #1;

    // K=1 constant tile plus output latency
    fill_const(1, 16'h0100);
    run_job(1, 1'b1, -1);
    chk("t1_vld", 32'(O_OUT_VLD), 32'd0);
    chk("t1_busy", 32'(O_BUSY), 32'd1);
    chk("t1_in_rdy", 32'(O_IN_RDY), 32'd0);
    @(posedge I_CLK); #1;
    chk("t2_vld", 32'(O_OUT_VLD), 32'd1);
    chk("t2_busy", 32'(O_BUSY), 32'd0);
    drain_queue();

    // K=3 accumulation, without and with input gaps
    fill_const(3, 16'h2000);
    run_job(3, 1'b1, -1);
    gap_pct = 40;
    run_job(3, 1'b0, -1);
    gap_pct = 0;

    // Deskew pattern {j, r}
    for (int r = 0; r < SA_R; r++)
      for (int c = 0; c < SA_C; c++) part[0][r][c] = {8'(c), 8'(r)};
    run_job(1, 1'b1, -1);

    // Overflow in both directions
    fill_const(2, 16'h6000);
    run_job(2, 1'b1, -1);
    fill_const(2, 16'hA000);
    run_job(2, 1'b1, -1);

    // K=0 is one tile
    fill_rand(1, 1'b0);
    run_job(0, 1'b0, -1);
    drain_queue();

    // Backpressure: tile A parked, job B waits in DRAIN
    I_OUT_RDY = 1'b0;
    fill_rand(1, 1'b0);
    run_job(1, 1'b0, -1);
    repeat (2) @(posedge I_CLK);
    #1;
    exp_a = exp_q[0];
    fill_rand(2, 1'b1);
    run_job(2, 1'b0, -1);
    exp_b = exp_q[1];
    repeat (3) @(posedge I_CLK);
    #1;
    chk("bp_busy", 32'(O_BUSY), 32'd1);
    chk("bp_in_rdy", 32'(O_IN_RDY), 32'd0);
    chk("bp_vld", 32'(O_OUT_VLD), 32'd1);
    chk_tile("bp_out_a", O_OUT, exp_a);
    I_OUT_RDY = 1'b1;
    @(posedge I_CLK); #1;
    I_OUT_RDY = 1'b0;
    chk("bp_vld_b", 32'(O_OUT_VLD), 32'd1);
    chk("bp_busy_b", 32'(O_BUSY), 32'd0);
    chk_tile("bp_out_b", O_OUT, exp_b);
    I_OUT_RDY = 1'b1;
    drain_queue();

    // Randomised jobs with random backpressure and gaps
    rdy_rand = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int k;
      k = int'($urandom_range(1, 4));
      gap_pct = int'($urandom_range(0, 50));
      fill_rand(k, (i % 2) == 1);
      run_job(k, 1'b0, -1);
    end
    gap_pct = 0;
    drain_queue();
    rdy_rand = 1'b0;
    @(posedge I_CLK); #1;
    I_OUT_RDY = 1'b1;

    // Reset in tile 1 of 3, then a clean job
    fill_rand(3, 1'b1);
    run_job(3, 1'b0, int'(BEATS) + 10);
    I_RST = 1'b1;
    @(posedge I_CLK); #1;
    chk("mr_vld", 32'(O_OUT_VLD), 32'd0);
    chk("mr_busy", 32'(O_BUSY), 32'd0);
    chk("mr_in_rdy", 32'(O_IN_RDY), 32'd0);
    chk("mr_sat", 32'(O_SAT), 32'd0);
    chk_tile("mr_out", O_OUT, '0);
    I_RST = 1'b0;
    @(posedge I_CLK); #1;
    for (int r = 0; r < SA_R; r++)
      for (int c = 0; c < SA_C; c++) part[0][r][c] = {8'(c), 8'(r)};
    run_job(1, 1'b1, -1);
    drain_queue();

    repeat (2) @(posedge I_CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa_out_accum_buf.md
# sa_out_accum_buf

Output-side successor to the systolic-array wrapper. It takes the column-skewed partial-result stream leaving the SA, deskews it into a tile buffer, and accumulates K partial tiles in Q2.13 fixed point with optional saturation. It then presents the finished SA_R×SA_C tile through a valid/ready output handshake. The output bank is double-buffered, so a new job can accumulate while the previous tile waits for the consumer.

## Interface
- D_W, 16: data width, signed fixed point (1 sign, 2 int, D_W-3 frac).
- SA_R, 16: tile rows (stream length per column).
- SA_C, 16: tile columns (channels).
- K_W, 4: width of the partial-tile count.

Ports:
- I_CLK  in  1  clock, all state on rising edge.
- I_RST  in  1  reset, asynchronous, active-high.
- I_START  in  1  job start pulse; sampled only in IDLE.
- I_K_TILES  in  K_W  partial tiles to accumulate; 0 is treated as 1.
- I_D_VLD  in  1  input beat valid.
- I_D  in  [0:SA_C-1] x D_W  skewed column outputs of the SA.
- O_IN_RDY  out  1  high in ACCUM only; a beat is accepted when I_D_VLD && O_IN_RDY.
- O_BUSY  out  1  state != IDLE.
- O_OUT_VLD  out  1  output tile valid.
- I_OUT_RDY  in  1  consumer ready.
- O_OUT  out  [0:SA_R-1][0:SA_C-1] x D_W  result tile.
- O_SAT  out  1  a clamp occurred during the job that produced O_OUT.

## Operation
- FSM states: IDLE, ACCUM, DRAIN.
  - IDLE → ACCUM on I_START. This latches k_total = max(I_K_TILES,1) and clears tile_cnt, beat_cnt and sat_acc.
  - ACCUM: each accepted beat increments beat_cnt (range 0..SA_R+SA_C-2).
  - At beat SA_R+SA_C-2, beat_cnt returns to 0 and tile_cnt increments.
  - If that was tile k_total-1, the FSM goes to DRAIN.
  - DRAIN: if the output bank is free (O_OUT_VLD==0, or O_OUT_VLD && I_OUT_RDY in this cycle), copy accum bank and sat_acc to O_OUT/O_SAT, set O_OUT_VLD, and go to IDLE. Otherwise hold in DRAIN.
- Deskew rule: on beat b, column j is live iff j ≤ b < j+SA_R. It then targets row r = b-j. Non-live lanes are ignored.
- Accumulate rule for a live lane:
  - Tile 0 overwrites: acc[r][j] = I_D[j].
  - Later tiles add: acc[r][j] = acc[r][j] + I_D[j].
  - The add is computed at D_W+1 bits, then reduced per Configuration.
- Gaps in I_D_VLD stall the counters; the result is unaffected.
- I_START outside IDLE is ignored. I_D_VLD outside ACCUM is ignored, and no counters move.
- Output handshake:
  - O_OUT and O_SAT are stable while O_OUT_VLD && !I_OUT_RDY.
  - On handshake, O_OUT_VLD falls next cycle, unless DRAIN copies in on the same edge; then it stays high with the new data.
- Reset (any time, including mid-job): state IDLE. All counters, acc bank, O_OUT, O_SAT and O_OUT_VLD go to 0. The in-flight job is discarded. Reset values: O_IN_RDY=0, O_BUSY=0.

## Timing
- O_IN_RDY rises the cycle after I_START is sampled in IDLE.
- Final beat accepted at edge T → DRAIN during cycle T+1. With a free bank, O_OUT_VLD=1 from T+2 and O_BUSY=0 from T+2.
- Minimum job length: k_total·(SA_R+SA_C-1) beats + 2 cycles to output.
- A new I_START is accepted in the first IDLE cycle, so back-to-back jobs lose 1 cycle.
- All outputs are registered; there is no combinational path from I_D or I_OUT_RDY to outputs, except that the DRAIN copy decision uses I_OUT_RDY.

## Configuration
- SA_ACC_SAT_EN defined:
  - Sums above 2^(D_W-1)-1 clamp to 0x7FFF.
  - Sums below -2^(D_W-1) clamp to 0x8000.
  - Any clamp sets sat_acc.
- SA_ACC_SAT_EN undefined: sums wrap modulo 2^D_W and O_SAT is tied to 0.

## Test plan
- K=1, all live lanes 0x0100 for 31 beats → O_OUT all 0x0100. O_OUT_VLD at T+2, O_SAT=0.
- K=3, each tile all 0x2000 (1.0) → O_OUT all 0x6000, O_SAT=0. Random I_D_VLD gaps give an identical result.
- Deskew pattern: lane j on beat b carries {j[7:0],(b-j)[7:0]}, and non-live lanes carry 0xDEAD → O_OUT[r][j] = {j,r} for every r and j. No 0xDEAD appears.
- Overflow, K=2:
  - 0x6000+0x6000 → 0x7FFF with O_SAT=1.
  - 0xA000+0xA000 → 0x8000 with O_SAT=1.
  - Without SA_ACC_SAT_EN → 0xC000 and 0x4000 respectively, with O_SAT=0.
- Backpressure:
  - Tile A valid with I_OUT_RDY=0; job B completes → stays in DRAIN, O_IN_RDY=0, O_OUT=A stable.
  - Raise I_OUT_RDY for 1 cycle → next cycle O_OUT=B with O_OUT_VLD held high.
- Reset pulse mid-ACCUM (tile 1 of 3) → next cycle all outputs 0, O_BUSY=0. A fresh K=1 job then yields the correct result with no residue.
